// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: width codes, fault codes,
// FSM states and the access-legality helpers.
package dmem_pkg;

    localparam logic [2:0] W_B  = 3'b000;
    localparam logic [2:0] W_H  = 3'b001;
    localparam logic [2:0] W_W  = 3'b010;
    localparam logic [2:0] W_BU = 3'b100;
    localparam logic [2:0] W_HU = 3'b101;

    typedef enum logic [1:0] {
        OK       = 2'b00,
        MISALIGN = 2'b01,
        RANGE    = 2'b10,
        ILLEGAL  = 2'b11
    } dmem_fault_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT   = 2'b01,
        ST_ACCESS = 2'b10,
        ST_RESP   = 2'b11
    } dmem_state_t;

    // Unsigned widths only make sense for loads.
    function automatic logic width_illegal(input logic [2:0] width, input logic we);
        case (width)
            W_B, W_H, W_W: return 1'b0;
            W_BU, W_HU:    return we;
            default:       return 1'b1;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] width, input logic [1:0] lo);
        case (width)
            W_H, W_HU: return lo[0];
            W_W:       return (lo != 2'b00);
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte/halfword lane steering: merges store data into the stored word and
// extracts/extends load data from it.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [2:0]  i_width,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_wword,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection and load extension
    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'b00:   w_byte = i_word[7:0];
            2'b01:   w_byte = i_word[15:8];
            2'b10:   w_byte = i_word[23:16];
            2'b11:   w_byte = i_word[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
        case (i_width)
            W_B:     o_rdata = {{24{w_byte[7]}}, w_byte};
            W_H:     o_rdata = {{16{w_half[15]}}, w_half};
            W_W:     o_rdata = i_word;
            W_BU:    o_rdata = {24'h000000, w_byte};
            W_HU:    o_rdata = {16'h0000, w_half};
            default: o_rdata = 32'h0000_0000;
        endcase
    end

    // Read-modify-write merge; untouched lanes keep the stored value
    always_comb begin
        o_wword = i_word;
        case (i_width)
            W_B, W_BU: begin
                case (i_addr_lo)
                    2'b00:   o_wword[7:0]   = i_wdata[7:0];
                    2'b01:   o_wword[15:8]  = i_wdata[7:0];
                    2'b10:   o_wword[23:16] = i_wdata[7:0];
                    2'b11:   o_wword[31:24] = i_wdata[7:0];
                    default: o_wword        = i_word;
                endcase
            end
            W_H, W_HU: begin
                if (i_addr_lo[1]) begin
                    o_wword[31:16] = i_wdata[15:0];
                end else begin
                    o_wword[15:0] = i_wdata[15:0];
                end
            end
            W_W:     o_wword = i_wdata;
            default: o_wword = i_word;
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Word-storage data memory with valid/ready request and response channels,
// configurable wait states and fault reporting. One request outstanding.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_width,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       o_rsp_rdata,
    output logic [1:0]        o_rsp_fault
);

    localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int         CMP_W     = ADDR_W + 32;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    dmem_state_t       r_state, w_state_nxt;
    logic [3:0]        r_wait_cnt, w_wait_cnt_nxt;
    logic              r_we;
    logic [2:0]        r_width;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    dmem_fault_t       r_rsp_fault;
    logic [31:0]       r_mem [DEPTH_WORDS];

    logic [ADDR_W-3:0] w_word_idx;
    logic [IDX_W-1:0]  w_mem_idx;
    logic              w_in_range;
    logic              w_commit;
    logic [31:0]       w_stored, w_wword, w_rdata;
    dmem_fault_t       w_fault;

    assign w_word_idx  = r_addr[ADDR_W-1:2];
    assign w_mem_idx   = w_word_idx[IDX_W-1:0];
    assign w_in_range  = (CMP_W'(w_word_idx) < CMP_W'(DEPTH_WORDS));
    assign w_stored    = r_mem[w_mem_idx];
    assign w_commit    = (r_state == ST_ACCESS) && r_we && (w_fault == OK);

    assign o_req_ready = (r_state == ST_IDLE);
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_fault = r_rsp_fault;

    dmem_lane_unit u_lane (
        .i_width   (r_width),
        .i_addr_lo (r_addr[1:0]),
        .i_word    (w_stored),
        .i_wdata   (r_wdata),
        .o_wword   (w_wword),
        .o_rdata   (w_rdata)
    );

    // Fault priority: illegal width, then range, then alignment
    always_comb begin
        w_fault = OK;
        if (width_illegal(r_width, r_we)) begin
            w_fault = ILLEGAL;
        end else if (!w_in_range) begin
            w_fault = RANGE;
        end else if (misaligned(r_width, r_addr[1:0])) begin
            w_fault = MISALIGN;
        end else begin
            w_fault = OK;
        end
    end

    // Next-state and wait-counter logic
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    if (WAIT_STATES > 0) begin
                        w_state_nxt    = ST_WAIT;
                        w_wait_cnt_nxt = WAIT_LOAD;
                    end else begin
                        w_state_nxt = ST_ACCESS;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 4'd1;
                end
            end
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (i_rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and wait counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Request capture on accept; reset drops any uncommitted store
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_width <= 3'b000;
            r_addr  <= '0;
            r_wdata <= 32'h0000_0000;
        end else if ((r_state == ST_IDLE) && i_req_valid) begin
            r_we    <= i_req_we;
            r_width <= i_req_width;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
        end else begin
            r_we    <= r_we;
            r_width <= r_width;
            r_addr  <= r_addr;
            r_wdata <= r_wdata;
        end
    end

    // Response registers: loaded in ACCESS, held until the consumer takes them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
            r_rsp_fault <= OK;
        end else if (r_state == ST_ACCESS) begin
            r_rsp_valid <= 1'b1;
            r_rsp_fault <= w_fault;
            r_rsp_rdata <= ((w_fault == OK) && !r_we) ? w_rdata : 32'h0000_0000;
        end else if ((r_state == ST_RESP) && i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end else begin
            r_rsp_valid <= r_rsp_valid;
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[w_mem_idx] <= w_wword;
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: instance 0 has no wait states,
// instance 1 has three.
module tb_data_memory_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [2:0]  req_width [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic [1:0]  rsp_fault [2];

    int errors = 0;
    int checks = 0;

    data_memory_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(0), .ADDR_W(32)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]), .i_req_we(req_we[0]),
        .i_req_width(req_width[0]), .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]),
        .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
        .o_rsp_rdata(rsp_rdata[0]), .o_rsp_fault(rsp_fault[0])
    );

    data_memory_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(3), .ADDR_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]), .i_req_we(req_we[1]),
        .i_req_width(req_width[1]), .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]),
        .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
        .o_rsp_rdata(rsp_rdata[1]), .o_rsp_fault(rsp_fault[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request; optionally leave the response un-acknowledged.
    task automatic do_req(input int s, input logic we, input logic [2:0] w,
                          input logic [31:0] a, input logic [31:0] d, input bit hold,
                          output logic [31:0] rd, output logic [1:0] f);
        int lat;
        int exp_lat;
        exp_lat = (s == 1) ? 5 : 2;
        @(negedge clk);
        checks++;
        if (req_ready[s] !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_req dut%0d: got %b want 1", s, req_ready[s]);
        end
        req_valid[s] = 1'b1; req_we[s] = we; req_width[s] = w;
        req_addr[s] = a; req_wdata[s] = d;
        @(posedge clk);
        #1 req_valid[s] = 1'b0;
        lat = 0;
        while (rsp_valid[s] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL latency dut%0d addr=%h: got %0d want %0d", s, a, lat, exp_lat);
        end
        rd = rsp_rdata[s];
        f  = rsp_fault[s];
        if (!hold) begin
            rsp_ready[s] = 1'b1;
            @(posedge clk);
            #1 rsp_ready[s] = 1'b0;
            checks++;
            if (rsp_valid[s] !== 1'b0) begin
                errors++;
                $display("FAIL rsp_drop dut%0d: got %b want 0", s, rsp_valid[s]);
            end
        end
    endtask

    task automatic expect_rsp(input string name, input logic [31:0] rd, input logic [1:0] f,
                              input logic [31:0] exp_rd, input logic [1:0] exp_f);
        checks++;
        if (rd !== exp_rd || f !== exp_f) begin
            errors++;
            $display("FAIL %s: got rdata=%h fault=%b want rdata=%h fault=%b",
                     name, rd, f, exp_rd, exp_f);
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0; req_we[s] = 1'b0; req_width[s] = 3'b000;
            req_addr[s] = 32'h0; req_wdata[s] = 32'h0; rsp_ready[s] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (req_ready[s] !== 1'b1 || rsp_valid[s] !== 1'b0 ||
                rsp_rdata[s] !== 32'h0 || rsp_fault[s] !== 2'b00) begin
                errors++;
                $display("FAIL reset_state dut%0d: ready=%b valid=%b rdata=%h fault=%b want 1 0 0 00",
                         s, req_ready[s], rsp_valid[s], rsp_rdata[s], rsp_fault[s]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic [1:0] f;
        do_req(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, rd, f);
        expect_rsp("sw_resp", rd, f, 32'h0, 2'b00);
        do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, f);
        expect_rsp("lw_0x10", rd, f, 32'hDEADBEEF, 2'b00);
    endtask

    task automatic test_lanes();
        logic [31:0] rd; logic [1:0] f;
        do_req(0, 1'b0, 3'b000, 32'h13, 32'h0, 1'b0, rd, f);
        expect_rsp("lb_0x13", rd, f, 32'hFFFFFFDE, 2'b00);
        do_req(0, 1'b0, 3'b100, 32'h13, 32'h0, 1'b0, rd, f);
        expect_rsp("lbu_0x13", rd, f, 32'h000000DE, 2'b00);
        do_req(0, 1'b0, 3'b001, 32'h12, 32'h0, 1'b0, rd, f);
        expect_rsp("lh_0x12", rd, f, 32'hFFFFDEAD, 2'b00);
        do_req(0, 1'b0, 3'b101, 32'h10, 32'h0, 1'b0, rd, f);
        expect_rsp("lhu_0x10", rd, f, 32'h0000BEEF, 2'b00);
        do_req(0, 1'b0, 3'b000, 32'h10, 32'h0, 1'b0, rd, f);
        expect_rsp("lb_0x10", rd, f, 32'hFFFFFFEF, 2'b00);
    endtask

    task automatic test_partial_store();
        logic [31:0] rd; logic [1:0] f;
        do_req(0, 1'b1, 3'b000, 32'h11, 32'hAAAAAA55, 1'b0, rd, f);
        do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, f);
        expect_rsp("sb_then_lw", rd, f, 32'hDEAD55EF, 2'b00);
        do_req(0, 1'b1, 3'b001, 32'h12, 32'hBBBB1234, 1'b0, rd, f);
        do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, f);
        expect_rsp("sh_then_lw", rd, f, 32'h123455EF, 2'b00);
    endtask

    task automatic test_faults();
        logic [31:0] rd; logic [1:0] f;
        do_req(0, 1'b1, 3'b010, 32'h0, 32'h11223344, 1'b0, rd, f);
        do_req(0, 1'b0, 3'b010, 32'h12, 32'h0, 1'b0, rd, f);
        expect_rsp("lw_misalign", rd, f, 32'h0, 2'b01);
        do_req(0, 1'b1, 3'b010, 32'h400, 32'hFFFFFFFF, 1'b0, rd, f);
        expect_rsp("sw_range", rd, f, 32'h0, 2'b10);
        do_req(0, 1'b1, 3'b101, 32'h10, 32'hFFFFFFFF, 1'b0, rd, f);
        expect_rsp("shu_illegal", rd, f, 32'h0, 2'b11);
        do_req(0, 1'b0, 3'b011, 32'h401, 32'h0, 1'b0, rd, f);
        expect_rsp("illegal_over_range", rd, f, 32'h0, 2'b11);
        do_req(0, 1'b0, 3'b010, 32'h402, 32'h0, 1'b0, rd, f);
        expect_rsp("range_over_misalign", rd, f, 32'h0, 2'b10);
        do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, f);
        expect_rsp("lw_0x10_unchanged", rd, f, 32'h123455EF, 2'b00);
        do_req(0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, rd, f);
        expect_rsp("lw_0x0_unchanged", rd, f, 32'h11223344, 2'b00);
    endtask

    task automatic test_wait_backpressure();
        logic [31:0] rd; logic [1:0] f;
        do_req(1, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 1'b0, rd, f);
        do_req(1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b1, rd, f);
        expect_rsp("ws3_lw", rd, f, 32'hCAFEF00D, 2'b00);
        // Stray store while the response is stalled must be ignored
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_width[1] = 3'b010;
        req_addr[1] = 32'h20; req_wdata[1] = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 32'hCAFEF00D || req_ready[1] !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable cyc%0d: valid=%b rdata=%h ready=%b want 1 cafef00d 0",
                         i, rsp_valid[1], rsp_rdata[1], req_ready[1]);
            end
        end
        rsp_ready[1] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[1] = 1'b0;
        req_valid[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL after_handshake: ready=%b valid=%b want 1 0", req_ready[1], rsp_valid[1]);
        end
        do_req(1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, rd, f);
        expect_rsp("stray_ignored", rd, f, 32'hCAFEF00D, 2'b00);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic [1:0] f;
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_width[1] = 3'b010;
        req_addr[1] = 32'h20; req_wdata[1] = 32'h0BADBEEF;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0 ||
            rsp_rdata[1] !== 32'h0 || rsp_fault[1] !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset: ready=%b valid=%b rdata=%h fault=%b want 1 0 0 00",
                     req_ready[1], rsp_valid[1], rsp_rdata[1], rsp_fault[1]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_req(1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, rd, f);
        expect_rsp("store_dropped", rd, f, 32'hCAFEF00D, 2'b00);
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_word();
        test_lanes();
        test_partial_store();
        test_faults();
        test_wait_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
